// File: rtl/tag_attribute_sequencer.sv
// -----------------------------------------------------------------------------
// tag_attribute_sequencer
//
// Drives attribute extraction for one HTML start tag. After the tag-name
// stage pulses tag_start, this block skips whitespace, enables the external
// attribute parser once per attribute, and collects each finished
// (type, value) pair. Each pair becomes one indexed write to the tag's
// attribute table. A '>' closes the tag and produces a tag_done pulse.
//
// Ports
//   clock, reset_n          : single clock, asynchronous active-low reset
//   tag_start               : one-cycle pulse, tag name consumed
//   char, char_valid        : incoming stream character
//   char_ready              : character consumed when char_valid && char_ready
//   attr_enable             : parser state_enable (low clears the parser)
//   attr_finished           : parser has_finished
//   attr_type, attr_value   : parser result
//   out_valid               : one-cycle attribute table write strobe
//   out_index               : table slot for the write
//   out_type, out_value     : table write data (registered, held stable)
//   tag_done                : one-cycle pulse, tag closed
//   attr_count              : attributes written for the current tag
//   error                   : sticky until the next tag_start
//   dbg_state               : current FSM state (debug visibility)
//
// Stream handshake: a character moves from the reader to this block on a
// rising clock edge where char_valid && char_ready are both high. The reader
// holds char stable while char_valid is high and char_ready is low. char_ready
// depends only on the current state and on char/char_valid, never on
// attr_finished.
// -----------------------------------------------------------------------------
module tag_attribute_sequencer #(
    parameter  int TYPE_W         = 4,
    parameter  int VAL_W          = 16,
    parameter  int MAX_ATTRS      = 8,
    parameter  int MAX_ATTR_CHARS = 32,
    localparam int IDX_W          = $clog2(MAX_ATTRS),
    localparam int CC_W           = $clog2(MAX_ATTR_CHARS + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tag_start,
    input  logic [7:0]        char,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              attr_enable,
    input  logic              attr_finished,
    input  logic [TYPE_W-1:0] attr_type,
    input  logic [VAL_W-1:0]  attr_value,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_index,
    output logic [TYPE_W-1:0] out_type,
    output logic [VAL_W-1:0]  out_value,
    output logic              tag_done,
    output logic [IDX_W:0]    attr_count,
    output logic              error,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SKIP_WS = 3'd1,
        S_ATTR    = 3'd2,
        S_FLUSH   = 3'd3,
        S_COMMIT  = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    localparam logic [7:0]   CH_GT    = 8'h3E;
    localparam logic [IDX_W:0] ATTR_MAX = (IDX_W + 1)'(MAX_ATTRS);
    localparam logic [CC_W-1:0] CHAR_MAX = CC_W'(MAX_ATTR_CHARS);

    state_e              state_q, state_d;
    logic [IDX_W:0]      attr_count_q, attr_count_d;
    logic                error_q, error_d;
    logic [CC_W-1:0]     char_cnt_q, char_cnt_d;
    logic                end_tag_q, end_tag_d;
    logic                wr_pend_q, wr_pend_d;
    logic                flush_cnt_q, flush_cnt_d;
    logic [TYPE_W-1:0]   type_q, type_d;
    logic [VAL_W-1:0]    value_q, value_d;

    logic                gt_in;

    function automatic logic is_ws(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            attr_count_q <= '0;
            error_q      <= 1'b0;
            char_cnt_q   <= '0;
            end_tag_q    <= 1'b0;
            wr_pend_q    <= 1'b0;
            flush_cnt_q  <= 1'b0;
            type_q       <= '0;
            value_q      <= '0;
        end else begin
            state_q      <= state_d;
            attr_count_q <= attr_count_d;
            error_q      <= error_d;
            char_cnt_q   <= char_cnt_d;
            end_tag_q    <= end_tag_d;
            wr_pend_q    <= wr_pend_d;
            flush_cnt_q  <= flush_cnt_d;
            type_q       <= type_d;
            value_q      <= value_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        attr_count_d = attr_count_q;
        error_d      = error_q;
        char_cnt_d   = char_cnt_q;
        end_tag_d    = end_tag_q;
        wr_pend_d    = wr_pend_q;
        flush_cnt_d  = flush_cnt_q;
        type_d       = type_q;
        value_d      = value_q;
        char_ready   = 1'b0;
        attr_enable  = 1'b0;
        out_valid    = 1'b0;
        tag_done     = 1'b0;
        gt_in        = char_valid && (char == CH_GT);

        case (state_q)
            S_IDLE: begin
                if (tag_start) begin
                    attr_count_d = '0;
                    error_d      = 1'b0;
                    state_d      = S_SKIP_WS;
                end
            end

            S_SKIP_WS: begin
                if (char_valid) begin
                    if (is_ws(char)) begin
                        char_ready = 1'b1;
                    end else if (char == CH_GT) begin
                        char_ready = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        // Leave the character in place so the parser sees it
                        // as the first character of the attribute.
                        char_cnt_d = '0;
                        end_tag_d  = 1'b0;
                        wr_pend_d  = 1'b0;
                        state_d    = S_ATTR;
                    end
                end
            end

            S_ATTR: begin
                attr_enable = 1'b1;
                char_ready  = 1'b1;
                if (char_valid && (char_cnt_q != CHAR_MAX)) begin
                    char_cnt_d = char_cnt_q + 1'b1;
                end
                if (attr_finished) begin
                    type_d    = attr_type;
                    value_d   = attr_value;
                    wr_pend_d = 1'b1;
                    end_tag_d = gt_in;
                    state_d   = S_COMMIT;
                end else if (gt_in) begin
                    // Tag closed before the parser reported: give it a short
                    // window to finish (e.g. a value terminated by '>').
                    flush_cnt_d = 1'b0;
                    state_d     = S_FLUSH;
                end else if (!char_valid) begin
                    error_d   = 1'b1;
                    wr_pend_d = 1'b0;
                    end_tag_d = 1'b0;
                    state_d   = S_COMMIT;
                end else if (char_cnt_d == CHAR_MAX) begin
                    error_d   = 1'b1;
                    wr_pend_d = 1'b0;
                    end_tag_d = 1'b0;
                    state_d   = S_COMMIT;
                end
            end

            S_FLUSH: begin
                attr_enable = 1'b1;
                if (attr_finished) begin
                    type_d    = attr_type;
                    value_d   = attr_value;
                    wr_pend_d = 1'b1;
                    end_tag_d = 1'b1;
                    state_d   = S_COMMIT;
                end else if (flush_cnt_q) begin
                    // Parser never finished: treat as a valueless (boolean)
                    // attribute and drop it without flagging an error.
                    state_d = S_DONE;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end

            S_COMMIT: begin
                // attr_enable stays low here, which clears the parser
                // between attributes.
                if (wr_pend_q) begin
                    if (attr_count_q < ATTR_MAX) begin
                        out_valid    = 1'b1;
                        attr_count_d = attr_count_q + 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                wr_pend_d = 1'b0;
                state_d   = end_tag_q ? S_DONE : S_SKIP_WS;
            end

            S_DONE: begin
                tag_done = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write slot is the count before the increment; index and data come
    // straight from registers so they are stable whenever out_valid is high.
    assign out_index  = attr_count_q[IDX_W-1:0];
    assign out_type   = type_q;
    assign out_value  = value_q;
    assign attr_count = attr_count_q;
    assign error      = error_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_tag_attribute_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for tag_attribute_sequencer. A small behavioural attribute parser
// sits beside the DUT: it accumulates one name letter (c/i/w/other -> type
// 0/1/2/3) and a decimal value after '=', and reports has_finished in the
// cycle the value terminator (whitespace or '>') is presented. A late mode
// makes it report one cycle after a terminating '>'.
// -----------------------------------------------------------------------------
module tb_tag_attribute_sequencer;

    localparam int TYPE_W = 4;
    localparam int VAL_W  = 16;
    localparam int IDX_W  = 3;
    localparam int WR_W   = IDX_W + TYPE_W + VAL_W;
    localparam int DN_W   = 1 + IDX_W + 1 + 1;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic              tag_start  = 1'b0;
    logic [7:0]        char_in    = 8'h00;
    logic              char_valid = 1'b0;
    logic              char_ready;
    logic              attr_enable;
    logic              attr_finished;
    logic [TYPE_W-1:0] attr_type;
    logic [VAL_W-1:0]  attr_value;
    logic              out_valid;
    logic [IDX_W-1:0]  out_index;
    logic [TYPE_W-1:0] out_type;
    logic [VAL_W-1:0]  out_value;
    logic              tag_done;
    logic [IDX_W:0]    attr_count;
    logic              error;
    logic [2:0]        dbg_state;

    tag_attribute_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .tag_start     (tag_start),
        .char          (char_in),
        .char_valid    (char_valid),
        .char_ready    (char_ready),
        .attr_enable   (attr_enable),
        .attr_finished (attr_finished),
        .attr_type     (attr_type),
        .attr_value    (attr_value),
        .out_valid     (out_valid),
        .out_index     (out_index),
        .out_type      (out_type),
        .out_value     (out_value),
        .tag_done      (tag_done),
        .attr_count    (attr_count),
        .error         (error),
        .dbg_state     (dbg_state)
    );

    // ---------------- parser model ----------------
    logic              p_phase  = 1'b0;
    logic [TYPE_W-1:0] p_type   = '0;
    logic [VAL_W-1:0]  p_value  = '0;
    logic              p_pend   = 1'b0;
    logic              late_fin = 1'b0;
    logic              p_fin;

    function automatic logic is_term(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D) || (c == 8'h3E);
    endfunction

    function automatic logic [TYPE_W-1:0] type_of(input logic [7:0] c);
        if (c == 8'h63) return 4'd0;      // 'c'
        if (c == 8'h69) return 4'd1;      // 'i'
        if (c == 8'h77) return 4'd2;      // 'w'
        return 4'd3;
    endfunction

    always_comb begin
        p_fin = 1'b0;
        if (attr_enable) begin
            if (p_pend) begin
                p_fin = 1'b1;
            end else if (p_phase && char_valid && is_term(char_in) &&
                         !(late_fin && (char_in == 8'h3E))) begin
                p_fin = 1'b1;
            end
        end
    end

    assign attr_finished = p_fin;
    assign attr_type     = p_type;
    assign attr_value    = p_value;

    always @(posedge clock) begin
        if (!attr_enable) begin
            p_phase <= 1'b0;
            p_type  <= '0;
            p_value <= '0;
            p_pend  <= 1'b0;
        end else if (char_valid && char_ready) begin
            if (!p_phase) begin
                if (char_in == 8'h3D) p_phase <= 1'b1;
                else if (char_in >= 8'h61 && char_in <= 8'h7A) p_type <= type_of(char_in);
            end else if (char_in >= 8'h30 && char_in <= 8'h39) begin
                p_value <= p_value * 16'd10 + {8'd0, char_in - 8'h30};
            end else if (late_fin && char_in == 8'h3E) begin
                p_pend <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [WR_W-1:0] wr_exp_q[$];   // {index, type, value}
    logic [DN_W-1:0] dn_exp_q[$];   // {check_adjacent, attr_count, error}
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_wr_cyc = -10;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic exp_wr(input int idx, input int typ, input int val);
        wr_exp_q.push_back({IDX_W'(idx), TYPE_W'(typ), VAL_W'(val)});
    endtask

    task automatic exp_done(input bit adj, input int cnt, input bit err);
        dn_exp_q.push_back({adj, (IDX_W + 1)'(cnt), err});
    endtask

    // Monitor: compares every write strobe and tag_done pulse.
    always @(negedge clock) begin
        logic [WR_W-1:0] wexp;
        logic [DN_W-1:0] dexp;
        if (reset_n) begin
            if (out_valid) begin
                n_tests++;
                if (wr_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: got idx=%0d type=%0d value=%0d, required no write",
                             out_index, out_type, out_value);
                end else begin
                    wexp = wr_exp_q.pop_front();
                    if ({out_index, out_type, out_value} !== wexp) begin
                        n_fail++;
                        $display("FAIL wr: got idx=%0d type=%0d value=%0d, required idx=%0d type=%0d value=%0d",
                                 out_index, out_type, out_value,
                                 wexp[WR_W-1 -: IDX_W], wexp[VAL_W +: TYPE_W], wexp[VAL_W-1:0]);
                    end
                end
                last_wr_cyc = cyc;
            end
            if (tag_done) begin
                n_tests++;
                if (dn_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: got tag_done count=%0d error=%0d, required none",
                             attr_count, error);
                end else begin
                    dexp = dn_exp_q.pop_front();
                    if ({attr_count, error} !== dexp[DN_W-2:0]) begin
                        n_fail++;
                        $display("FAIL done: got count=%0d error=%0d, required count=%0d error=%0d",
                                 attr_count, error, dexp[DN_W-2:1], dexp[0]);
                    end
                    if (dexp[DN_W-1]) begin
                        n_tests++;
                        if (cyc != last_wr_cyc + 1) begin
                            n_fail++;
                            $display("FAIL done_adjacent: got %0d cycles after write, required 1",
                                     cyc - last_wr_cyc);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_tag();
        tag_start = 1'b1;
        @(posedge clock); #1;
        tag_start = 1'b0;
    endtask

    // '~' in the string means: present no valid character for one cycle.
    task automatic drive_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "~") begin
                char_valid = 1'b0;
                @(posedge clock); #1;
            end else begin
                int   budget;
                logic acc;
                budget     = 0;
                acc        = 1'b0;
                char_valid = 1'b1;
                char_in    = s[i];
                while (!acc && budget < 50) begin
                    @(negedge clock);
                    acc = char_valid && char_ready;
                    @(posedge clock); #1;
                    budget++;
                end
                if (!acc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL drive_timeout: char %0d not consumed, required within 50 cycles", i);
                end
            end
        end
        char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (dbg_state != 3'd0 && b < 20) begin
            @(posedge clock); #1;
            b++;
        end
        if (b >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got state=%0d, required 0 within 20 cycles", dbg_state);
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        string s;
        #12;
        check("reset_outputs",
              {28'd0, out_valid, tag_done, char_ready, attr_enable}, 32'd0);
        check("reset_regs",
              {19'd0, error, attr_count, out_index, out_type}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        // Two valued attributes
        exp_wr(0, 0, 5); exp_wr(1, 2, 12); exp_done(1'b0, 2, 1'b0);
        start_tag(); drive_str(" c=5 w=12>"); wait_idle();

        // Empty tag
        exp_done(1'b0, 0, 1'b0);
        start_tag(); drive_str(">"); wait_idle();

        // Nine attributes into an eight-entry table
        for (int k = 1; k <= 8; k++) exp_wr(k - 1, 1, k);
        exp_done(1'b0, 8, 1'b1);
        start_tag(); drive_str("i=1 i=2 i=3 i=4 i=5 i=6 i=7 i=8 i=9 >"); wait_idle();

        // Over-long attribute aborted after 32 characters, next one still written
        s = "x";
        for (int k = 0; k < 40; k++) s = {s, "z"};
        s = {s, " c=3>"};
        exp_wr(0, 0, 3); exp_done(1'b0, 1, 1'b1);
        start_tag(); drive_str(s); wait_idle();

        // Parser finishes on '>': DONE right after the write
        exp_wr(0, 0, 7); exp_done(1'b1, 1, 1'b0);
        start_tag(); drive_str(" c=7>"); wait_idle();

        // Boolean attribute: flush expires, no write, no error
        exp_done(1'b0, 0, 1'b0);
        start_tag(); drive_str(" b>"); wait_idle();

        // Parser finishes one cycle after '>' (inside the flush window)
        late_fin = 1'b1;
        exp_wr(0, 0, 4); exp_done(1'b0, 1, 1'b0);
        start_tag(); drive_str(" c=4>"); wait_idle();
        late_fin = 1'b0;

        // Stream underrun inside an attribute
        exp_done(1'b0, 0, 1'b1);
        start_tag(); drive_str(" w=1~2>"); wait_idle();

        // Asynchronous reset mid-attribute
        start_tag(); drive_str(" w=");
        char_in = "4"; char_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("midreset_outputs",
              {28'd0, out_valid, tag_done, char_ready, attr_enable}, 32'd0);
        check("midreset_regs",
              {29'd0, dbg_state} | {19'd0, error, attr_count, out_index, out_type}, 32'd0);
        check("midreset_value", {16'd0, out_value}, 32'd0);
        char_valid = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock); #1;
        check("postreset_state", {29'd0, dbg_state}, 32'd0);

        // Normal operation resumes after reset
        exp_wr(0, 0, 9); exp_done(1'b0, 1, 1'b0);
        start_tag(); drive_str(" c=9>"); wait_idle();

        check("queues_drained", wr_exp_q.size() + dn_exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
